trigger_fifo_arbiter: RTL

Round-robin arbiter that shares the single Pulse Trigger FIFO write port between two trigger-information producers: the asynchronous front-panel pulse trigger receiver (source 0) and the synchronous TTC trigger receiver (source 1). It stamps each accepted 128-bit word with a source tag and presents it through a registered valid/ready output stage to the FIFO. It also keeps per-source accepted-word counters and an output stall counter for the status registers.

---
 rtl/trigger_pkg.sv | 14 +
 rtl/trigger_fifo_arbiter_rr_arbiter2.sv | 22 ++
 rtl/trigger_fifo_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/trigger_pkg.sv
// Shared constants for the pulse-trigger FIFO arbitration slice:
// source tags, tag position and arbiter state encoding.
package trigger_pkg;

    localparam logic [1:0] SRC_TAG_ASYNC = 2'b01;
    localparam logic [1:0] SRC_TAG_SYNC  = 2'b10;
    localparam int         TAG_LSB       = 126;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/trigger_fifo_arbiter_rr_arbiter2.sv
// Two-input round-robin grant: a tie goes to the requester that did not
// win last time; nothing is granted while enable is low.
module rr_arbiter2 (
    input  logic       enable,
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);
    import trigger_pkg::*;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                grant = last_grant ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

endmodule

// File: rtl/trigger_fifo_arbiter.sv
// Shares the Pulse Trigger FIFO write port between the async front-panel
// receiver (source 0) and the TTC receiver (source 1), with status counters.
module trigger_fifo_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int TAG_LSB    = trigger_pkg::TAG_LSB,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_counters,
    input  logic [1:0]            src_en,
    input  logic                  src0_valid,
    input  logic [DATA_WIDTH-1:0] src0_data,
    output logic                  src0_ready,
    input  logic                  src1_valid,
    input  logic [DATA_WIDTH-1:0] src1_data,
    output logic                  src1_ready,
    output logic                  fifo_valid,
    output logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_ready,
    output logic                  last_grant,
    output logic [CNT_WIDTH-1:0]  src0_word_count,
    output logic [CNT_WIDTH-1:0]  src1_word_count,
    output logic [CNT_WIDTH-1:0]  stall_count
);
    import trigger_pkg::*;

    state_t                state;
    logic                  out_free;
    logic [1:0]            req;
    logic [1:0]            grant;
    logic [DATA_WIDTH-1:0] tagged0;
    logic [DATA_WIDTH-1:0] tagged1;

    // Reset gates the enable so no producer sees a ready while in reset.
    assign out_free   = (state == IDLE) || fifo_ready;
    assign req        = {src1_valid & src_en[1], src0_valid & src_en[0]};
    assign src0_ready = grant[0];
    assign src1_ready = grant[1];
    assign fifo_valid = (state == SEND);

    rr_arbiter2 u_arb (
        .enable     (out_free & ~reset),
        .req        (req),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_comb begin
        tagged0 = src0_data;
        tagged1 = src1_data;
        tagged0[TAG_LSB +: 2] = SRC_TAG_ASYNC;
        tagged1[TAG_LSB +: 2] = SRC_TAG_SYNC;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            fifo_data  <= '0;
            last_grant <= 1'b1;
        end else if (grant[0]) begin
            state      <= SEND;
            fifo_data  <= tagged0;
            last_grant <= 1'b0;
        end else if (grant[1]) begin
            state      <= SEND;
            fifo_data  <= tagged1;
            last_grant <= 1'b1;
        end else if (state == SEND && fifo_ready) begin
            state      <= IDLE;
            fifo_data  <= '0;
        end
    end

    // Clear wins over a same-cycle increment; the stall counter saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src0_word_count <= '0;
            src1_word_count <= '0;
            stall_count     <= '0;
        end else if (clear_counters) begin
            src0_word_count <= '0;
            src1_word_count <= '0;
            stall_count     <= '0;
        end else begin
            if (grant[0]) src0_word_count <= src0_word_count + CNT_WIDTH'(1);
            if (grant[1]) src1_word_count <= src1_word_count + CNT_WIDTH'(1);
            if (state == SEND && !fifo_ready && stall_count != '1)
                stall_count <= stall_count + CNT_WIDTH'(1);
        end
    end

endmodule
